seq_mant_div: RTL and testbench

Parametrised, iterative non-restoring unsigned divider for the FP ALU mantissa path. It replaces a fully unrolled combinational array with one add/subtract stage reused over WIDTH cycles. It adds a valid/ready handshake, a corrected remainder, a divide-by-zero flag and abort. It sits between the FP divide pre-normaliser and the rounding/normalise stage.

---
 rtl/mantdiv_pkg.sv | 28 ++
 rtl/nr_div_step.sv | 31 +++
 rtl/seq_mant_div.sv | 154 +++++++++++++++
 tb/tb_seq_mant_div.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mantdiv_pkg.sv
// Shared types and constants for the sequential mantissa divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, step-counter width helper, divide-by-zero
// quotient constant (all ones of a given width, right-aligned in 64 bits).
package mantdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // All-ones quotient returned on divide by zero; caller slices [WIDTH-1:0].
    function automatic logic [63:0] dbz_quot(input int width);
        logic [63:0] ones;
        ones = '1;
        return ones >> (64 - width);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step: shift partial remainder, add or subtract divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only when the FSM iterates.
//
// Ports:
//   i_p      partial remainder, WIDTH+1 bits, two's complement
//   i_q_msb  bit shifted in from the top of the dividend/quotient register
//   i_d      unsigned divisor
//   o_p_next updated partial remainder
//   o_q_bit  quotient bit produced by this step
module nr_div_step #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH:0]   i_p,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_p_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_d_ext;

    // The shift drops P's sign bit; the true result always lies in [-D, D),
    // so wrapping modulo 2^(WIDTH+1) still yields the exact value.
    assign w_shift  = {i_p[WIDTH-1:0], i_q_msb};
    assign w_d_ext  = {1'b0, i_d};
    assign o_p_next = i_p[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
    assign o_q_bit  = ~o_p_next[WIDTH];

endmodule

// File: rtl/seq_mant_div.sv
// Iterative non-restoring unsigned divider for the FP mantissa divide path.
// Latency: result valid WIDTH+1 edges after accept; divide-by-zero valid 1 edge after accept.
// Backpressure: single op in flight; in_ready low until the result is taken, result held while out_ready low.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid/in_ready   operand handshake (dividend, divisor)
//   abort               cancels an op in CALC or FIX; ignored in IDLE and DONE
//   out_valid/out_ready result handshake (quotient, remainder, dbz)
//   sticky              |remainder (forced 1 on divide by zero); present only
//                       when MANTDIV_STICKY_EN is defined
module seq_mant_div
    import mantdiv_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
`ifdef MANTDIV_STICKY_EN
    ,
    output logic             sticky
`endif
);

    localparam logic [63:0] DBZ_QUOT_FULL = dbz_quot(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_QUOT = DBZ_QUOT_FULL[WIDTH-1:0];

    state_t           r_state;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_p_next;
    logic             w_q_bit;
    logic [WIDTH:0]   w_p_fix;

    nr_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p      (r_p),
        .i_q_msb  (r_q[WIDTH-1]),
        .i_d      (r_d),
        .o_p_next (w_p_next),
        .o_q_bit  (w_q_bit)
    );

    // Final correction: a negative partial remainder is one divisor short.
    assign w_p_fix = r_p[WIDTH] ? (r_p + {1'b0, r_d}) : r_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_p       <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
`ifdef MANTDIV_STICKY_EN
            sticky    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // abort is deliberately not looked at here.
                    if (in_valid && in_ready) begin
                        r_d      <= divisor;
                        r_q      <= dividend;
                        r_p      <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // Result is known now; out_valid rises on the
                            // first DONE cycle.
                            quotient  <= DBZ_QUOT;
                            remainder <= dividend;
                            dbz       <= 1'b1;
`ifdef MANTDIV_STICKY_EN
                            sticky    <= 1'b1;
`endif
                            r_state   <= DONE;
                        end else begin
                            r_state   <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (abort) begin
                        in_ready <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_p   <= w_p_next;
                        r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                        r_cnt <= r_cnt - CNT_W'(1);
                        // Counter still 1 means this is the last of WIDTH steps.
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= FIX;
                        end
                    end
                end

                FIX: begin
                    if (abort) begin
                        in_ready <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        quotient  <= r_q;
                        remainder <= w_p_fix[WIDTH-1:0];
                        dbz       <= 1'b0;
`ifdef MANTDIV_STICKY_EN
                        sticky    <= |w_p_fix[WIDTH-1:0];
`endif
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        // Only reached on the divide-by-zero path.
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mant_div.sv
module tb_seq_mant_div;

    logic clk;
    logic rst_n;

    // WIDTH = 25 instance
    logic        a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready, a_dbz;
    logic [24:0] a_dividend, a_divisor, a_quotient, a_remainder;
    // WIDTH = 8 instance
    logic        b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_dbz;
    logic [7:0]  b_dividend, b_divisor, b_quotient, b_remainder;
`ifdef MANTDIV_STICKY_EN
    logic        a_sticky, b_sticky;
`endif

    int n_checks;
    int n_fail;

    seq_mant_div #(.WIDTH(25)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .dividend  (a_dividend),
        .divisor   (a_divisor),
        .abort     (a_abort),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .quotient  (a_quotient),
        .remainder (a_remainder),
        .dbz       (a_dbz)
`ifdef MANTDIV_STICKY_EN
        ,
        .sticky    (a_sticky)
`endif
    );

    seq_mant_div #(.WIDTH(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .dividend  (b_dividend),
        .divisor   (b_divisor),
        .abort     (b_abort),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .quotient  (b_quotient),
        .remainder (b_remainder),
        .dbz       (b_dbz)
`ifdef MANTDIV_STICKY_EN
        ,
        .sticky    (b_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Runs one op on the 25-bit instance; lat = edges from accept to out_valid
    // (-1 if in_ready never came, 200 if out_valid never came).
    task automatic op_a(input logic [24:0] dd, input logic [24:0] dv, input logic ab,
                        output int lat, output logic [24:0] q, output logic [24:0] r,
                        output logic z, output logic s);
        int g;
        g = 0;
        while (!a_in_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (!a_in_ready) begin lat = -1; q = '0; r = '0; z = 1'b0; s = 1'b0; return; end
        a_dividend = dd; a_divisor = dv; a_abort = ab; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_abort = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        q = a_quotient; r = a_remainder; z = a_dbz;
`ifdef MANTDIV_STICKY_EN
        s = a_sticky;
`else
        s = 1'b0;
`endif
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic op_b(input logic [7:0] dd, input logic [7:0] dv,
                        output int lat, output logic [7:0] q, output logic [7:0] r,
                        output logic z, output logic s);
        int g;
        g = 0;
        while (!b_in_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (!b_in_ready) begin lat = -1; q = '0; r = '0; z = 1'b0; s = 1'b0; return; end
        b_dividend = dd; b_divisor = dv; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        q = b_quotient; r = b_remainder; z = b_dbz;
`ifdef MANTDIV_STICKY_EN
        s = b_sticky;
`else
        s = 1'b0;
`endif
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_quotient !== 25'd0 ||
            a_remainder !== 25'd0 || a_dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h dbz=%b, want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_quotient, a_remainder, a_dbz);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [24:0] dd [4] = '{25'd100, 25'd5, 25'h1FFFFFF, 25'h1FFFFFF};
        logic [24:0] dv [4] = '{25'd7, 25'd9, 25'd1, 25'h1FFFFFF};
        logic [24:0] eq [4] = '{25'd14, 25'd0, 25'h1FFFFFF, 25'd1};
        logic [24:0] er [4] = '{25'd2, 25'd5, 25'd0, 25'd0};
        int lat; logic [24:0] q, r; logic z, s;
        for (int i = 0; i < 4; i++) begin
            op_a(dd[i], dv[i], 1'b0, lat, q, r, z, s);
            n_checks++;
            if (lat !== 26 || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_%0d: lat=%0d q=%h r=%h dbz=%b, want lat=26 q=%h r=%h dbz=0",
                         i, lat, q, r, z, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_dbz();
        int lat; logic [24:0] q, r; logic z, s;
        op_a(25'd123, 25'd0, 1'b0, lat, q, r, z, s);
        n_checks++;
        if (lat !== 1 || q !== 25'h1FFFFFF || r !== 25'd123 || z !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz: lat=%0d q=%h r=%h dbz=%b, want lat=1 q=1ffffff r=7b dbz=1",
                     lat, q, r, z);
        end
`ifdef MANTDIV_STICKY_EN
        n_checks++;
        if (s !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_sticky: sticky=%b, want 1", s);
        end
`endif
    endtask

    task automatic test_backpressure();
        int g, lat; logic [24:0] q, r; logic z, s;
        a_dividend = 25'd100; a_divisor = 25'd7; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        g = 0;
        while (!a_out_valid && g < 100) begin @(posedge clk); #1; g++; end
        // Result must hold; new operands and abort must be ignored.
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1; a_dividend = 25'd77; a_divisor = 25'd3; a_abort = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (a_out_valid !== 1'b1 || a_quotient !== 25'd14 || a_remainder !== 25'd2 ||
                a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: out_valid=%b q=%h r=%h in_ready=%b, want 1 e 2 0",
                         i, a_out_valid, a_quotient, a_remainder, a_in_ready);
            end
        end
        a_in_valid = 1'b0; a_abort = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", a_out_valid, a_in_ready);
        end
        op_a(25'd77, 25'd3, 1'b0, lat, q, r, z, s);
        n_checks++;
        if (lat !== 26 || q !== 25'd25 || r !== 25'd2) begin
            n_fail++;
            $display("FAIL after_hold: lat=%0d q=%h r=%h, want lat=26 q=19 r=2", lat, q, r);
        end
    endtask

    task automatic test_abort();
        int lat; logic [24:0] q, r; logic z, s;
        a_dividend = 25'd1000; a_divisor = 25'd7; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_calc: in_ready=%b out_valid=%b, want 1 0", a_in_ready, a_out_valid);
        end
        op_a(25'd50, 25'd5, 1'b0, lat, q, r, z, s);
        n_checks++;
        if (lat !== 26 || q !== 25'd10 || r !== 25'd0 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort: lat=%0d q=%h r=%h dbz=%b, want lat=26 q=a r=0 dbz=0",
                     lat, q, r, z);
        end
        // abort together with in_valid in IDLE: operand still accepted
        op_a(25'd40, 25'd3, 1'b1, lat, q, r, z, s);
        n_checks++;
        if (lat !== 26 || q !== 25'd13 || r !== 25'd1) begin
            n_fail++;
            $display("FAIL abort_idle: lat=%0d q=%h r=%h, want lat=26 q=d r=1", lat, q, r);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [24:0] q, r; logic z, s;
        a_dividend = 25'd1000; a_divisor = 25'd7; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_quotient !== 25'd0 ||
            a_remainder !== 25'd0 || a_dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%h r=%h dbz=%b, want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_quotient, a_remainder, a_dbz);
        end
        rst_n = 1'b1;
        op_a(25'd9, 25'd2, 1'b0, lat, q, r, z, s);
        n_checks++;
        if (lat !== 26 || q !== 25'd4 || r !== 25'd1) begin
            n_fail++;
            $display("FAIL after_reset: lat=%0d q=%h r=%h, want lat=26 q=4 r=1", lat, q, r);
        end
    endtask

    task automatic test_random_w25();
        int lat; logic [24:0] q, r, dd, dv, eq, er; logic z, s, ez;
        for (int i = 0; i < 100; i++) begin
            dd = 25'($urandom);
            dv = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(1, 50)) : 25'($urandom);
            if (i % 20 == 7) dv = '0;
            if (dv == '0) begin eq = '1; er = dd; ez = 1'b1; end
            else begin eq = dd / dv; er = dd % dv; ez = 1'b0; end
            op_a(dd, dv, 1'b0, lat, q, r, z, s);
            n_checks++;
            if (lat !== (ez ? 1 : 26) || q !== eq || r !== er || z !== ez) begin
                n_fail++;
                $display("FAIL rand25_%0d: %h/%h lat=%0d q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, dd, dv, lat, q, r, z, eq, er, ez);
            end
`ifdef MANTDIV_STICKY_EN
            n_checks++;
            if (s !== (ez | (|er))) begin
                n_fail++;
                $display("FAIL rand25_sticky_%0d: sticky=%b, want %b", i, s, ez | (|er));
            end
`endif
        end
    endtask

    task automatic test_random_w8();
        int lat; logic [7:0] q, r, dd, dv, eq, er; logic z, s, ez;
        for (int i = 0; i < 300; i++) begin
            dd = 8'($urandom);
            dv = 8'($urandom);
            if (i % 25 == 3) dv = '0;
            if (i == 0) begin dd = 8'hFF; dv = 8'h01; end
            if (i == 1) begin dd = 8'h03; dv = 8'hFF; end
            if (dv == '0) begin eq = '1; er = dd; ez = 1'b1; end
            else begin eq = dd / dv; er = dd % dv; ez = 1'b0; end
            op_b(dd, dv, lat, q, r, z, s);
            n_checks++;
            if (lat !== (ez ? 1 : 9) || q !== eq || r !== er || z !== ez) begin
                n_fail++;
                $display("FAIL rand8_%0d: %h/%h lat=%0d q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, dd, dv, lat, q, r, z, eq, er, ez);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_abort = 1'b0; a_out_ready = 1'b0; a_dividend = '0; a_divisor = '0;
        b_in_valid = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0; b_dividend = '0; b_divisor = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_dbz();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random_w25();
        test_random_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
